// File: rtl/fsctl_commit_seq.sv
// Commit sequencer: waits for all stream engines to reach a frame boundary, holds the
// pipeline in soft reset, strobes shadow->active geometry latch, then releases and reports.
module fsctl_commit_seq #(
  parameter int                        C_STREAMS      = 3,
  parameter int                        C_RST_CYCLES   = 16,
  parameter int                        C_TIMEOUT_BITS = 24,
  parameter logic [C_TIMEOUT_BITS-1:0] C_TIMEOUT      = 24'd1000000,
  parameter int                        C_CNT_BITS     = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_ctl_enable,
  input  logic                  i_cmd_commit,
  input  logic                  i_cmd_force,
  input  logic [C_STREAMS-1:0]  i_s_idle,
  output logic                  o_soft_resetn,
  output logic                  o_cfg_latch,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [C_CNT_BITS-1:0] o_commit_cnt
);

  localparam int RST_W = (C_RST_CYCLES > 1) ? $clog2(C_RST_CYCLES) : 1;
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(C_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_IDLE,
    S_ASSERT_RST,
    S_LATCH,
    S_RELEASE
  } state_t;

  state_t                    r_state;
  logic                      r_pending;
  logic [C_TIMEOUT_BITS-1:0] r_wait_cnt;
  logic [RST_W-1:0]          r_rst_cnt;
  logic                      r_soft_resetn;
  logic                      r_cfg_latch;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_timeout;
  logic [C_CNT_BITS-1:0]     r_commit_cnt;

  logic w_all_idle;
  logic w_tmo_hit;

  assign w_all_idle = &i_s_idle;
  assign w_tmo_hit  = (C_TIMEOUT != '0) && (r_wait_cnt == C_TIMEOUT);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_pending     <= 1'b0;
      r_wait_cnt    <= '0;
      r_rst_cnt     <= '0;
      r_soft_resetn <= 1'b0;
      r_cfg_latch   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout     <= 1'b0;
      r_commit_cnt  <= '0;
    end else begin
      r_cfg_latch   <= 1'b0;
      r_soft_resetn <= i_ctl_enable;
      // Requests arriving mid-commit (including during RELEASE) coalesce into one follow-up.
      if (r_state != S_IDLE && i_cmd_commit)
        r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_cmd_commit || r_pending) begin
            r_state    <= S_WAIT_IDLE;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_pending  <= 1'b0;
            r_wait_cnt <= '0;
          end
        end

        S_WAIT_IDLE: begin
          if (w_all_idle || i_cmd_force || w_tmo_hit) begin
            r_state       <= S_ASSERT_RST;
            r_rst_cnt     <= RST_LOAD;
            r_soft_resetn <= 1'b0;
            // Only a genuine timeout is flagged; idle and force take precedence.
            r_timeout     <= w_tmo_hit && !w_all_idle && !i_cmd_force;
          end else begin
            r_wait_cnt <= r_wait_cnt + C_TIMEOUT_BITS'(1);
          end
        end

        S_ASSERT_RST: begin
          r_soft_resetn <= 1'b0;
          if (r_rst_cnt == '0) begin
            r_state     <= S_LATCH;
            r_cfg_latch <= 1'b1;
          end else begin
            r_rst_cnt <= r_rst_cnt - RST_W'(1);
          end
        end

        S_LATCH: begin
          r_state      <= S_RELEASE;
          r_done       <= 1'b1;
          r_commit_cnt <= r_commit_cnt + C_CNT_BITS'(1);
        end

        S_RELEASE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_soft_resetn = r_soft_resetn;
  assign o_cfg_latch   = r_cfg_latch;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_timeout     = r_timeout;
  assign o_commit_cnt  = r_commit_cnt;

endmodule

// File: tb/tb_fsctl_commit_seq.sv
// Directed bench for fsctl_commit_seq: C_RST_CYCLES=4, C_TIMEOUT=100, 4-bit commit counter.
module tb_fsctl_commit_seq;
  logic       clk = 1'b0;
  logic       resetn;
  logic       ctl_enable;
  logic       cmd_commit;
  logic       cmd_force;
  logic [2:0] s_idle;
  logic       soft_resetn;
  logic       cfg_latch;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [3:0] commit_cnt;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_cnt = 4'd0;

  fsctl_commit_seq #(
    .C_STREAMS(3), .C_RST_CYCLES(4), .C_TIMEOUT_BITS(24),
    .C_TIMEOUT(24'd100), .C_CNT_BITS(4)
  ) dut (
    .clk(clk), .resetn(resetn), .i_ctl_enable(ctl_enable),
    .i_cmd_commit(cmd_commit), .i_cmd_force(cmd_force), .i_s_idle(s_idle),
    .o_soft_resetn(soft_resetn), .o_cfg_latch(cfg_latch), .o_busy(busy),
    .o_done(done), .o_timeout(timeout), .o_commit_cnt(commit_cnt)
  );

  always #5 clk = ~clk;

  // Advance into the next cycle; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; ctl_enable = 1'b1; cmd_commit = 1'b0; cmd_force = 1'b0; s_idle = 3'b111;
    step(); step();
    checks++;
    if ({soft_resetn, cfg_latch, busy, done, timeout, commit_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 000000000",
               {soft_resetn, cfg_latch, busy, done, timeout, commit_cnt});
    end
    resetn = 1'b1;
    step();
    checks++;
    if (soft_resetn !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release soft=%b busy=%b exp soft=1 busy=0", soft_resetn, busy);
    end
  endtask

  task automatic test_basic();
    logic exp_soft;
    s_idle = 3'b111; cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    for (int c = 1; c <= 8; c++) begin
      exp_soft = !(c >= 2 && c <= 6);
      checks++;
      if (soft_resetn !== exp_soft || cfg_latch !== (c == 6) || busy !== (c <= 7)) begin
        errors++;
        $display("FAIL basic c=%0d soft=%b latch=%b busy=%b exp soft=%b latch=%b busy=%b",
                 c, soft_resetn, cfg_latch, busy, exp_soft, (c == 6), (c <= 7));
      end
      if (c == 7) begin
        checks++;
        if (done !== 1'b1 || commit_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL basic_done done=%b cnt=%0d exp done=1 cnt=%0d", done, commit_cnt, exp_cnt);
        end
      end
      step();
    end
  endtask

  task automatic test_release_commit();
    logic exp_busy;
    s_idle = 3'b111;
    for (int c = 0; c <= 16; c++) begin
      if (c >= 1) begin
        exp_busy = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
        checks++;
        if (cfg_latch !== (c == 6 || c == 14) || busy !== exp_busy) begin
          errors++;
          $display("FAIL release_commit c=%0d latch=%b busy=%b exp latch=%b busy=%b",
                   c, cfg_latch, busy, (c == 6 || c == 14), exp_busy);
        end
      end
      cmd_commit = (c == 0 || c == 7);
      step();
    end
    cmd_commit = 1'b0;
    exp_cnt = exp_cnt + 4'd2;
    checks++;
    if (commit_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL release_commit_cnt got %0d exp %0d", commit_cnt, exp_cnt);
    end
  endtask

  task automatic test_wait_idle();
    logic exp_soft;
    for (int c = 0; c <= 27; c++) begin
      if (c >= 1) begin
        exp_soft = !(c >= 21 && c <= 25);
        checks++;
        if (soft_resetn !== exp_soft || cfg_latch !== (c == 25)) begin
          errors++;
          $display("FAIL wait_idle c=%0d soft=%b latch=%b exp soft=%b latch=%b",
                   c, soft_resetn, cfg_latch, exp_soft, (c == 25));
        end
      end
      if (c == 1) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL wait_idle_entry done=%b busy=%b exp done=0 busy=1", done, busy);
        end
      end
      if (c == 26) begin
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0) begin
          errors++;
          $display("FAIL wait_idle_done done=%b timeout=%b exp done=1 timeout=0", done, timeout);
        end
      end
      s_idle = (c >= 20) ? 3'b111 : 3'b101;
      cmd_commit = (c == 0);
      step();
    end
    cmd_commit = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
  endtask

  task automatic test_timeout();
    int n_latch;
    n_latch = 0;
    s_idle = 3'b011; cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    for (int c = 1; c <= 108; c++) begin
      if (cfg_latch === 1'b1) n_latch++;
      if (c == 101) begin
        checks++;
        if (soft_resetn !== 1'b1 || timeout !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL timeout_pre soft=%b to=%b busy=%b exp 1 0 1", soft_resetn, timeout, busy);
        end
      end
      if (c == 102) begin
        checks++;
        if (soft_resetn !== 1'b0 || timeout !== 1'b1) begin
          errors++;
          $display("FAIL timeout_hit soft=%b to=%b exp soft=0 to=1", soft_resetn, timeout);
        end
      end
      if (c == 106) begin
        checks++;
        if (cfg_latch !== 1'b1) begin
          errors++;
          $display("FAIL timeout_latch got %b exp 1", cfg_latch);
        end
      end
      if (c == 107) begin
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || commit_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL timeout_done done=%b to=%b cnt=%0d exp 1 1 %0d", done, timeout, commit_cnt, exp_cnt);
        end
      end
      if (c == 108) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL timeout_busy got %b exp 0", busy);
        end
      end
      step();
    end
    checks++;
    if (n_latch != 1) begin
      errors++;
      $display("FAIL timeout_latch_count got %0d exp 1", n_latch);
    end
  endtask

  task automatic test_force_coalesce();
    logic exp_busy;
    for (int c = 0; c <= 40; c++) begin
      if (c >= 1) begin
        exp_busy = (c <= 16) || (c >= 18 && c <= 36);
        checks++;
        if (cfg_latch !== (c == 15 || c == 35) || busy !== exp_busy) begin
          errors++;
          $display("FAIL force_coalesce c=%0d latch=%b busy=%b exp latch=%b busy=%b",
                   c, cfg_latch, busy, (c == 15 || c == 35), exp_busy);
        end
      end
      if (c == 16) begin
        checks++;
        if (done !== 1'b1 || timeout !== 1'b0 || commit_cnt !== exp_cnt + 4'd1) begin
          errors++;
          $display("FAIL force_first done=%b to=%b cnt=%0d exp 1 0 %0d", done, timeout, commit_cnt, exp_cnt + 4'd1);
        end
      end
      if (c == 36) begin
        checks++;
        if (commit_cnt !== exp_cnt + 4'd2) begin
          errors++;
          $display("FAIL force_followup_cnt got %0d exp %0d", commit_cnt, exp_cnt + 4'd2);
        end
      end
      s_idle = (c >= 30) ? 3'b111 : 3'b000;
      cmd_commit = (c == 0 || c == 12 || c == 14);
      cmd_force = (c == 10);
      step();
    end
    cmd_commit = 1'b0; cmd_force = 1'b0;
    exp_cnt = exp_cnt + 4'd2;
  endtask

  task automatic test_reset_mid();
    s_idle = 3'b111; cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0;
    step();
    cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0; resetn = 1'b0;
    step();
    resetn = 1'b1;
    checks++;
    if ({soft_resetn, cfg_latch, busy, done, timeout, commit_cnt} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b exp 000000000",
               {soft_resetn, cfg_latch, busy, done, timeout, commit_cnt});
    end
    for (int c = 5; c <= 15; c++) begin
      step();
      checks++;
      if (cfg_latch !== 1'b0 || busy !== 1'b0 || soft_resetn !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d latch=%b busy=%b soft=%b exp 0 0 1",
                 c, cfg_latch, busy, soft_resetn);
      end
    end
    exp_cnt = 4'd0;
    test_basic();
  endtask

  task automatic test_enable_off();
    ctl_enable = 1'b0; s_idle = 3'b111; cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0;
    exp_cnt = exp_cnt + 4'd1;
    for (int c = 1; c <= 9; c++) begin
      checks++;
      if (soft_resetn !== 1'b0 || cfg_latch !== (c == 6)) begin
        errors++;
        $display("FAIL enable_off c=%0d soft=%b latch=%b exp soft=0 latch=%b",
                 c, soft_resetn, cfg_latch, (c == 6));
      end
      if (c == 7) begin
        checks++;
        if (done !== 1'b1 || commit_cnt !== exp_cnt) begin
          errors++;
          $display("FAIL enable_off_done done=%b cnt=%0d exp 1 %0d", done, commit_cnt, exp_cnt);
        end
      end
      if (c == 9) ctl_enable = 1'b1;
      step();
    end
    checks++;
    if (soft_resetn !== 1'b1) begin
      errors++;
      $display("FAIL enable_on soft=%b exp 1", soft_resetn);
    end
  endtask

  task automatic test_wrap();
    s_idle = 3'b111;
    while (exp_cnt != 4'd15) begin
      cmd_commit = 1'b1;
      step();
      cmd_commit = 1'b0;
      repeat (8) step();
      exp_cnt = exp_cnt + 4'd1;
    end
    checks++;
    if (commit_cnt !== 4'd15) begin
      errors++;
      $display("FAIL wrap_pre got %0d exp 15", commit_cnt);
    end
    cmd_commit = 1'b1;
    step();
    cmd_commit = 1'b0;
    repeat (8) step();
    checks++;
    if (commit_cnt !== 4'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL wrap cnt=%0d done=%b exp cnt=0 done=1", commit_cnt, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_release_commit();
    test_wait_idle();
    test_timeout();
    test_force_coalesce();
    test_reset_mid();
    test_enable_off();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
